// File: rtl/vram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// vram_arbiter_pkg
// Shared types and constants for the video/CPU SRAM arbiter.
//   vram_arb_state_t : sequencer states (IDLE, ACCESS, RELEASE)
//   VRAM_CH_SCREEN   : fixed-priority screen-fetch channel index
//   VRAM_CH_CPU      : first round-robin channel (pointer reset/wrap value)
// ---------------------------------------------------------------------------
package vram_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RELEASE = 2'd2
   } vram_arb_state_t;

   localparam int unsigned VRAM_CH_SCREEN = 0;
   localparam int unsigned VRAM_CH_CPU    = 1;

endpackage

// File: rtl/vram_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational grant logic: channel 0 wins outright, otherwise the first
// requester at or after ptr_i among channels 1..NCH-1 (cyclic) wins.
//   req_i     : request vector
//   ptr_i     : round-robin start pointer (always 1..NCH-1)
//   excl_en_i : exclude channel excl_i from this evaluation
//   excl_i    : channel index to exclude
//   gnt_o     : one-hot grant
//   valid_o   : a grant was made
//   idx_o     : granted channel index
//   ptr_o     : pointer to use after this grant
// ---------------------------------------------------------------------------
module rr_arbiter
   import vram_arbiter_pkg::*;
#(
   parameter int unsigned NCH = 4,
   parameter int unsigned PW  = 2
) (
   input  logic [NCH-1:0] req_i,
   input  logic [PW-1:0]  ptr_i,
   input  logic           excl_en_i,
   input  logic [PW-1:0]  excl_i,
   output logic [NCH-1:0] gnt_o,
   output logic           valid_o,
   output logic [PW-1:0]  idx_o,
   output logic [PW-1:0]  ptr_o
);

   logic [NCH-1:0] req_m;
   int unsigned    c;

   always_comb begin
      req_m   = '0;
      gnt_o   = '0;
      valid_o = 1'b0;
      idx_o   = '0;
      ptr_o   = ptr_i;
      c       = 0;

      for (int unsigned i = 0; i < NCH; i++) begin
         req_m[i] = req_i[i] && !(excl_en_i && (excl_i == PW'(i)));
      end

      if (req_m[VRAM_CH_SCREEN]) begin
         // screen fetch does not move the round-robin pointer
         gnt_o[VRAM_CH_SCREEN] = 1'b1;
         valid_o               = 1'b1;
         idx_o                 = PW'(VRAM_CH_SCREEN);
      end else begin
         for (int unsigned i = 0; i < NCH - 1; i++) begin
            // ptr_i + i folded back into 1..NCH-1
            c = 32'(ptr_i) + i;
            if (c >= NCH) c = c - (NCH - 1);
            if (!valid_o && req_m[c[PW-1:0]]) begin
               gnt_o[c[PW-1:0]] = 1'b1;
               valid_o          = 1'b1;
               idx_o            = c[PW-1:0];
               ptr_o            = (c == NCH - 1) ? PW'(VRAM_CH_CPU) : PW'(c + 1);
            end
         end
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
// Multi-channel arbiter/sequencer for the shared video/CPU SRAM.
//   clk28, rst          : clock, synchronous active-high reset
//   ch_req/ch_wr/ch_wrmask/ch_addr/ch_wdata : per-channel request side
//   ch_ack, rdata       : completion pulse and read data
//   busy                : sequencer not idle
//   va, vd_in, vd_out, vd_oe, n_vwr, n_vrd : SRAM pin side (all registered)
// ---------------------------------------------------------------------------
module vram_arbiter
   import vram_arbiter_pkg::*;
#(
   parameter int unsigned NCH     = 4,
   parameter int unsigned AW      = 19,
   parameter int unsigned DW      = 8,
   parameter int unsigned ACC_CYC = 2
) (
   input  logic              clk28,
   input  logic              rst,
   input  logic [NCH-1:0]    ch_req,
   input  logic [NCH-1:0]    ch_wr,
   input  logic [NCH-1:0]    ch_wrmask,
   input  logic [NCH*AW-1:0] ch_addr,
   input  logic [NCH*DW-1:0] ch_wdata,
   output logic [NCH-1:0]    ch_ack,
   output logic [DW-1:0]     rdata,
   output logic              busy,
   output logic [AW-1:0]     va,
   input  logic [DW-1:0]     vd_in,
   output logic [DW-1:0]     vd_out,
   output logic              vd_oe,
   output logic              n_vwr,
   output logic              n_vrd
);

   localparam int unsigned PW       = $clog2(NCH);
   localparam logic [1:0]  CNT_LAST = 2'(ACC_CYC - 1);

   vram_arb_state_t state_q, state_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [PW-1:0]   g_q, g_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [AW-1:0]   va_q, va_d;
   logic [DW-1:0]   vdo_q, vdo_d;
   logic            wr_q, wr_d;
   logic            mask_q, mask_d;
   logic            vd_oe_q, vd_oe_d;
   logic            n_vwr_q, n_vwr_d;
   logic            n_vrd_q, n_vrd_d;
   logic [NCH-1:0]  ack_q, ack_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            busy_q, busy_d;

   logic [NCH-1:0]  gnt;
   logic            gnt_valid;
   logic [PW-1:0]   gnt_idx;
   logic [PW-1:0]   gnt_ptr;
   logic            load;

   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wdata;
   logic            sel_wr;
   logic            sel_mask;

   rr_arbiter #(
      .NCH (NCH),
      .PW  (PW)
   ) u_rr (
      .req_i     (ch_req),
      .ptr_i     (ptr_q),
      .excl_en_i (state_q == RELEASE),
      .excl_i    (g_q),
      .gnt_o     (gnt),
      .valid_o   (gnt_valid),
      .idx_o     (gnt_idx),
      .ptr_o     (gnt_ptr)
   );

   // one-hot AND-OR mux of the granted channel's request fields
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wr    = 1'b0;
      sel_mask  = 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (gnt[i]) begin
            sel_addr  = sel_addr  | ch_addr[i*AW +: AW];
            sel_wdata = sel_wdata | ch_wdata[i*DW +: DW];
            sel_wr    = sel_wr    | ch_wr[i];
            sel_mask  = sel_mask  | ch_wrmask[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      g_d     = g_q;
      ptr_d   = ptr_q;
      va_d    = va_q;
      vdo_d   = vdo_q;
      wr_d    = wr_q;
      mask_d  = mask_q;
      rdata_d = rdata_q;
      load    = 1'b0;

      case (state_q)
         IDLE: begin
            if (gnt_valid) load = 1'b1;
         end
         ACCESS: begin
            if (cnt_q == CNT_LAST) begin
               state_d = RELEASE;
               if (!wr_q) rdata_d = vd_in;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         RELEASE: begin
            if (gnt_valid) load = 1'b1;
            else           state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         state_d = ACCESS;
         cnt_d   = '0;
         g_d     = gnt_idx;
         ptr_d   = gnt_ptr;
         va_d    = sel_addr;
         vdo_d   = sel_wdata;
         wr_d    = sel_wr;
         mask_d  = sel_mask;
      end

      // pin outputs are registered: derive them from the next state so they
      // line up with the cycle that state is active
      busy_d  = (state_d != IDLE);
      n_vrd_d = !((state_d == ACCESS) && !wr_d);
      vd_oe_d = ((state_d == ACCESS) || (state_d == RELEASE)) && wr_d;
      n_vwr_d = !((state_d == ACCESS) && wr_d && !mask_d &&
                  ((ACC_CYC == 1) || (cnt_d != CNT_LAST)));
      ack_d   = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         ack_d[i] = (state_d == RELEASE) && (g_d == PW'(i));
      end
   end

   always_ff @(posedge clk28) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         g_q     <= '0;
         ptr_q   <= PW'(VRAM_CH_CPU);
         va_q    <= '0;
         vdo_q   <= '0;
         wr_q    <= 1'b0;
         mask_q  <= 1'b0;
         vd_oe_q <= 1'b0;
         n_vwr_q <= 1'b1;
         n_vrd_q <= 1'b1;
         ack_q   <= '0;
         rdata_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         g_q     <= g_d;
         ptr_q   <= ptr_d;
         va_q    <= va_d;
         vdo_q   <= vdo_d;
         wr_q    <= wr_d;
         mask_q  <= mask_d;
         vd_oe_q <= vd_oe_d;
         n_vwr_q <= n_vwr_d;
         n_vrd_q <= n_vrd_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         busy_q  <= busy_d;
      end
   end

   assign ch_ack = ack_q;
   assign rdata  = rdata_q;
   assign busy   = busy_q;
   assign va     = va_q;
   assign vd_out = vdo_q;
   assign vd_oe  = vd_oe_q;
   assign n_vwr  = n_vwr_q;
   assign n_vrd  = n_vrd_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
// Directed bench for vram_arbiter (NCH=4, AW=19, DW=8, ACC_CYC=2).
// "cycle k" is the clock period following rising edge k; inputs are driven
// and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

   localparam int unsigned NCH = 4;
   localparam int unsigned AW  = 19;
   localparam int unsigned DW  = 8;
   localparam int unsigned ACC = 2;

   logic              clk28 = 1'b0;
   logic              rst;
   logic [NCH-1:0]    ch_req;
   logic [NCH-1:0]    ch_wr;
   logic [NCH-1:0]    ch_wrmask;
   logic [NCH*AW-1:0] ch_addr;
   logic [NCH*DW-1:0] ch_wdata;
   logic [NCH-1:0]    ch_ack;
   logic [DW-1:0]     rdata;
   logic              busy;
   logic [AW-1:0]     va;
   logic [DW-1:0]     vd_in;
   logic [DW-1:0]     vd_out;
   logic              vd_oe;
   logic              n_vwr;
   logic              n_vrd;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk28 = ~clk28;

   vram_arbiter #(
      .NCH     (NCH),
      .AW      (AW),
      .DW      (DW),
      .ACC_CYC (ACC)
   ) dut (
      .clk28     (clk28),
      .rst       (rst),
      .ch_req    (ch_req),
      .ch_wr     (ch_wr),
      .ch_wrmask (ch_wrmask),
      .ch_addr   (ch_addr),
      .ch_wdata  (ch_wdata),
      .ch_ack    (ch_ack),
      .rdata     (rdata),
      .busy      (busy),
      .va        (va),
      .vd_in     (vd_in),
      .vd_out    (vd_out),
      .vd_oe     (vd_oe),
      .n_vwr     (n_vwr),
      .n_vrd     (n_vrd)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk28);
      #1;
   endtask

   function automatic logic [AW-1:0] addr_of(input int unsigned ch);
      return AW'(32'h100 * ch + 32'h40);
   endfunction

   task automatic load_addr_table();
      for (int unsigned i = 0; i < NCH; i++) ch_addr[i*AW +: AW] = addr_of(i);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   int unsigned seq [8] = '{1, 2, 3, 1, 2, 0, 3, 1};

   initial begin
      rst       = 1'b1;
      ch_req    = '0;
      ch_wr     = '0;
      ch_wrmask = '0;
      ch_addr   = '0;
      ch_wdata  = '0;
      vd_in     = '0;

      // ---- reset state ----
      tick(); tick(); tick();
      check("rst_va",    32'(va),     32'h0);
      check("rst_vdout", 32'(vd_out), 32'h0);
      check("rst_vdoe",  32'(vd_oe),  32'h0);
      check("rst_nvwr",  32'(n_vwr),  32'h1);
      check("rst_nvrd",  32'(n_vrd),  32'h1);
      check("rst_ack",   32'(ch_ack), 32'h0);
      check("rst_rdata", 32'(rdata),  32'h0);
      check("rst_busy",  32'(busy),   32'h0);
      rst = 1'b0;
      tick();

      // ---- single CPU read ----
      ch_addr[1*AW +: AW] = 19'h1ABCD;
      vd_in     = 8'h5A;
      ch_req[1] = 1'b1;
      tick(); // cycle 1
      check("rd_va_c1",   32'(va),     32'h1ABCD);
      check("rd_nvrd_c1", 32'(n_vrd),  32'h0);
      check("rd_busy_c1", 32'(busy),   32'h1);
      check("rd_ack_c1",  32'(ch_ack), 32'h0);
      check("rd_vdoe_c1", 32'(vd_oe),  32'h0);
      tick(); // cycle 2
      check("rd_nvrd_c2", 32'(n_vrd),  32'h0);
      check("rd_ack_c2",  32'(ch_ack), 32'h0);
      tick(); // cycle 3
      check("rd_ack_c3",   32'(ch_ack), 32'h2);
      check("rd_rdata_c3", 32'(rdata),  32'h5A);
      check("rd_nvrd_c3",  32'(n_vrd),  32'h1);
      ch_req[1] = 1'b0;
      vd_in     = 8'h00;
      tick(); // cycle 4
      check("rd_busy_c4",  32'(busy),   32'h0);
      check("rd_ack_c4",   32'(ch_ack), 32'h0);
      check("rd_rhold_c4", 32'(rdata),  32'h5A);

      // ---- unmasked and masked CPU writes ----
      for (int m = 0; m < 2; m++) begin
         ch_wdata[1*DW +: DW] = 8'hC3;
         ch_wr[1]     = 1'b1;
         ch_wrmask[1] = (m == 1);
         ch_req[1]    = 1'b1;
         tick(); // cycle 1
         check("wr_nvwr_c1",  32'(n_vwr),  (m == 1) ? 32'h1 : 32'h0);
         check("wr_vdoe_c1",  32'(vd_oe),  32'h1);
         check("wr_vdout_c1", 32'(vd_out), 32'hC3);
         check("wr_nvrd_c1",  32'(n_vrd),  32'h1);
         tick(); // cycle 2
         check("wr_nvwr_c2",  32'(n_vwr),  32'h1);
         check("wr_vdoe_c2",  32'(vd_oe),  32'h1);
         tick(); // cycle 3
         check("wr_nvwr_c3",  32'(n_vwr),  32'h1);
         check("wr_vdoe_c3",  32'(vd_oe),  32'h1);
         check("wr_ack_c3",   32'(ch_ack), 32'h2);
         ch_req[1] = 1'b0;
         tick(); // cycle 4
         check("wr_vdoe_c4",  32'(vd_oe),  32'h0);
         check("wr_busy_c4",  32'(busy),   32'h0);
         check("wr_rdata_c4", 32'(rdata),  32'h5A);
      end
      ch_wr     = '0;
      ch_wrmask = '0;

      // ---- fairness 1->2->3->1, then screen priority and pointer hold ----
      load_addr_table();
      do_reset();
      ch_req = 4'b1110;
      for (int c = 1; c <= 24; c++) begin
         tick();
         if (c % 3 == 0) check("rr_ack", 32'(ch_ack), 32'h1 << seq[c/3 - 1]);
         else            check("rr_ack_idle", 32'(ch_ack), 32'h0);
         if (c % 3 == 1) check("rr_va", 32'(va), 32'(addr_of(seq[c/3])));
         check("rr_busy", 32'(busy), 32'h1);
         if (c == 13) ch_req[0] = 1'b1;
         if (c == 18) ch_req[0] = 1'b0;
         if (c == 24) ch_req = '0;
      end
      tick();
      check("rr_end_busy", 32'(busy),   32'h0);
      check("rr_end_ack",  32'(ch_ack), 32'h0);

      // ---- reset on second ACCESS cycle of a write ----
      ch_wdata[1*DW +: DW] = 8'hC3;
      ch_wr[1]  = 1'b1;
      ch_req[1] = 1'b1;
      tick(); // cycle 1
      check("ra_nvwr_c1", 32'(n_vwr), 32'h0);
      tick(); // cycle 2
      check("ra_vdoe_c2", 32'(vd_oe), 32'h1);
      rst = 1'b1;
      tick(); // cycle 3
      check("ra_nvwr_c3", 32'(n_vwr),  32'h1);
      check("ra_vdoe_c3", 32'(vd_oe),  32'h0);
      check("ra_busy_c3", 32'(busy),   32'h0);
      check("ra_ack_c3",  32'(ch_ack), 32'h0);
      rst       = 1'b0;
      ch_req[1] = 1'b0;
      ch_wr[1]  = 1'b0;
      tick(); // cycle 4
      check("ra_ack_c4",  32'(ch_ack), 32'h0);
      check("ra_busy_c4", 32'(busy),   32'h0);

      // ---- request dropped after grant ----
      ch_req[1] = 1'b1;
      tick(); // cycle 1
      check("dr_busy_c1", 32'(busy), 32'h1);
      check("dr_va_c1",   32'(va),   32'(addr_of(1)));
      ch_req[1] = 1'b0;
      tick(); // cycle 2
      check("dr_ack_c2", 32'(ch_ack), 32'h0);
      tick(); // cycle 3
      check("dr_ack_c3", 32'(ch_ack), 32'h2);
      tick(); // cycle 4
      check("dr_ack_c4",  32'(ch_ack), 32'h0);
      check("dr_busy_c4", 32'(busy),   32'h0);
      tick(); // cycle 5
      check("dr_ack_c5", 32'(ch_ack), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
